cacheline_arbiter: RTL and testbench

CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

---
 rtl/cacheline_arbiter_if.sv | 33 +++
 rtl/cacheline_arbiter.sv | 145 ++++++++++++++
 tb/tb_cacheline_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_arbiter_if.sv
// Cache-side and memory-side signals around the cacheline arbiter.
// The arbiter uses "slave"; the caches and memory around it use "master".
interface cacheline_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between an
// instruction cache (read only) and a data cache (read and write-back).
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t            state_r;
  state_t            state_nxt_s;
  grant_t            last_grant_r;
  grant_t            last_grant_nxt_s;
  grant_t            grant_who_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [LINE_W-1:0] wdata_r;
  logic [LINE_W-1:0] wdata_nxt_s;
  logic              mem_read_r;
  logic              mem_read_nxt_s;
  logic              mem_write_r;
  logic              mem_write_nxt_s;
  logic              grant_write_s;
  logic              i_req_s;
  logic              d_req_s;
  logic              i_resp_s;
  logic              d_resp_s;

  // Winner selection: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    i_req_s = bus.i_read;
    d_req_s = bus.d_read | bus.d_write;
    if (i_req_s && d_req_s) begin
      grant_who_s = (last_grant_r == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req_s) begin
      grant_who_s = GRANT_D;
    end else begin
      grant_who_s = GRANT_I;
    end
  end

  // Next-state, transaction capture and response decode.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    addr_nxt_s       = addr_r;
    wdata_nxt_s      = wdata_r;
    mem_read_nxt_s   = 1'b0;
    mem_write_nxt_s  = 1'b0;
    grant_write_s    = 1'b0;
    i_resp_s         = 1'b0;
    d_resp_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req_s || d_req_s) begin
          last_grant_nxt_s = grant_who_s;
          if (grant_who_s == GRANT_D) begin
            state_nxt_s   = BUSY_D;
            addr_nxt_s    = bus.d_addr;
            wdata_nxt_s   = bus.d_wdata;
            // A simultaneous read and write-back resolves to the write-back.
            grant_write_s = bus.d_write;
          end else begin
            state_nxt_s   = BUSY_I;
            addr_nxt_s    = bus.i_addr;
            wdata_nxt_s   = {LINE_W{1'b0}};
            grant_write_s = 1'b0;
          end
          mem_read_nxt_s  = ~grant_write_s;
          mem_write_nxt_s = grant_write_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_I: begin
        if (bus.mem_resp) begin
          i_resp_s    = rst;
          state_nxt_s = DONE;
        end else begin
          mem_read_nxt_s  = mem_read_r;
          mem_write_nxt_s = mem_write_r;
        end
      end
      BUSY_D: begin
        if (bus.mem_resp) begin
          d_resp_s    = rst;
          state_nxt_s = DONE;
        end else begin
          mem_read_nxt_s  = mem_read_r;
          mem_write_nxt_s = mem_write_r;
        end
      end
      DONE: begin
        // One quiet cycle so a requester that just got its response can drop.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and captured-transaction registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_I;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {LINE_W{1'b0}};
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      mem_read_r   <= mem_read_nxt_s;
      mem_write_r  <= mem_write_nxt_s;
    end
  end

  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = mem_write_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.i_resp    = i_resp_s;
  assign bus.d_resp    = d_resp_s;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench: directed vector table, two hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_cacheline_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [LINE_W-1:0] LINE_A = {8{32'hA5A5_0A0A}};
  localparam logic [LINE_W-1:0] LINE_B = {8{32'h5B5B_B0B0}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cacheline_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [4:0]        in_bits;   // {rst, i_read, d_read, d_write, mem_resp}
    logic [3:0]        exp_bits;  // {mem_read, mem_write, i_resp, d_resp}
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] in_bits, input logic [3:0] exp_bits,
                     input logic [ADDR_W-1:0] exp_addr);
    vec_t v;
    v.in_bits  = in_bits;
    v.exp_bits = exp_bits;
    v.exp_addr = exp_addr;
    vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [LINE_W-1:0] act,
                           input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Random-phase environment and reference model state
  logic              i_act, d_act, d_r, d_w, i_drop, d_drop, loaded;
  logic [ADDR_W-1:0] ia, da;
  logic [LINE_W-1:0] dwd;
  int                lat;
  logic              m_busy, m_who, m_last, m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  int                m_cool;
  int                n_i_done, n_d_done;

  initial begin
    bus.i_read = 1'b0; bus.i_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_bit("reset.mem_read", bus.mem_read, 1'b0);
    check_bit("reset.mem_write", bus.mem_write, 1'b0);
    check_bit("reset.i_resp", bus.i_resp, 1'b0);
    check_bit("reset.d_resp", bus.d_resp, 1'b0);
    check_vec("reset.mem_addr", LINE_W'(bus.mem_addr), {LINE_W{1'b0}});
    check_vec("reset.mem_wdata", bus.mem_wdata, {LINE_W{1'b0}});
    tick();

    // I read alone, memory answers in the fifth busy cycle
    add(5'b1_1000, 4'b0000, 32'h0);
    for (int k = 0; k < 4; k++) add(5'b1_1000, 4'b1000, 32'h60);
    add(5'b1_1001, 4'b1010, 32'h60);
    add(5'b1_0000, 4'b0000, 32'h0);
    add(5'b1_0000, 4'b0000, 32'h0);
    // D write-back alone
    add(5'b1_0010, 4'b0000, 32'h0);
    add(5'b1_0010, 4'b0100, 32'h80);
    add(5'b1_0011, 4'b0101, 32'h80);
    add(5'b1_0000, 4'b0000, 32'h0);
    add(5'b1_0000, 4'b0000, 32'h0);
    // Reset restores last_grant=I, so D wins the tie, then I is served
    add(5'b0_0000, 4'b0000, 32'h0);
    add(5'b1_1100, 4'b0000, 32'h0);
    add(5'b1_1100, 4'b1000, 32'h80);
    add(5'b1_1101, 4'b1001, 32'h80);
    add(5'b1_1000, 4'b0000, 32'h0);
    add(5'b1_1000, 4'b0000, 32'h0);
    add(5'b1_1001, 4'b1010, 32'h60);
    add(5'b1_0000, 4'b0000, 32'h0);
    add(5'b1_0000, 4'b0000, 32'h0);
    // Read and write together resolve to a write; stray mem_resp in IDLE is ignored
    add(5'b1_0110, 4'b0000, 32'h0);
    add(5'b1_0110, 4'b0100, 32'h80);
    add(5'b1_0111, 4'b0101, 32'h80);
    add(5'b1_0000, 4'b0000, 32'h0);
    add(5'b1_0001, 4'b0000, 32'h0);
    add(5'b1_0000, 4'b0000, 32'h0);

    bus.i_addr = 32'h60; bus.d_addr = 32'h80; bus.d_wdata = LINE_B; bus.mem_rdata = LINE_A;
    foreach (vecs[k]) begin
      rst          = vecs[k].in_bits[4];
      bus.i_read   = vecs[k].in_bits[3];
      bus.d_read   = vecs[k].in_bits[2];
      bus.d_write  = vecs[k].in_bits[1];
      bus.mem_resp = vecs[k].in_bits[0];
      #1;
      check_bit($sformatf("v%0d.mem_read", k), bus.mem_read, vecs[k].exp_bits[3]);
      check_bit($sformatf("v%0d.mem_write", k), bus.mem_write, vecs[k].exp_bits[2]);
      check_bit($sformatf("v%0d.i_resp", k), bus.i_resp, vecs[k].exp_bits[1]);
      check_bit($sformatf("v%0d.d_resp", k), bus.d_resp, vecs[k].exp_bits[0]);
      if (vecs[k].exp_bits[3] || vecs[k].exp_bits[2])
        check_vec($sformatf("v%0d.mem_addr", k), LINE_W'(bus.mem_addr), LINE_W'(vecs[k].exp_addr));
      if (vecs[k].exp_bits[2])
        check_vec($sformatf("v%0d.mem_wdata", k), bus.mem_wdata, LINE_B);
      if (vecs[k].exp_bits[1])
        check_vec($sformatf("v%0d.i_rdata", k), bus.i_rdata, LINE_A);
      if (vecs[k].exp_bits[0])
        check_vec($sformatf("v%0d.d_rdata", k), bus.d_rdata, LINE_A);
      tick();
    end
    rst = 1'b1;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.mem_resp = 1'b0;

    // I address changes mid-transaction; memory keeps the granted address
    bus.i_read = 1'b1; bus.i_addr = 32'h60;
    tick();
    bus.i_addr = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_bit("hold.mem_read", bus.mem_read, 1'b1);
      check_vec("hold.mem_addr", LINE_W'(bus.mem_addr), LINE_W'(32'h60));
      tick();
    end
    bus.mem_resp = 1'b1;
    #1;
    check_bit("hold.i_resp", bus.i_resp, 1'b1);
    check_vec("hold.mem_addr_end", LINE_W'(bus.mem_addr), LINE_W'(32'h60));
    tick();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0;
    tick();
    tick();

    // Reset during BUSY_D abandons the transaction; a later mem_resp does nothing
    bus.d_read = 1'b1; bus.d_addr = 32'h80;
    tick();
    #1;
    check_bit("rstbusy.mem_read_before", bus.mem_read, 1'b1);
    rst = 1'b0; bus.d_read = 1'b0;
    tick();
    rst = 1'b1; bus.mem_resp = 1'b1;
    #1;
    check_bit("rstbusy.d_resp", bus.d_resp, 1'b0);
    check_bit("rstbusy.mem_read", bus.mem_read, 1'b0);
    check_bit("rstbusy.mem_write", bus.mem_write, 1'b0);
    check_vec("rstbusy.mem_addr", LINE_W'(bus.mem_addr), {LINE_W{1'b0}});
    tick();
    bus.mem_resp = 1'b0;
    #1;
    check_bit("rstbusy.d_resp_late", bus.d_resp, 1'b0);
    check_bit("rstbusy.mem_read_late", bus.mem_read, 1'b0);
    tick();

    // Randomized traffic; the model predicts each grant from the round-robin rule
    i_act = 1'b0; d_act = 1'b0; d_r = 1'b0; d_w = 1'b0; i_drop = 1'b0; d_drop = 1'b0;
    ia = '0; da = '0; dwd = '0; loaded = 1'b0; lat = 0;
    m_busy = 1'b0; m_who = 1'b0; m_last = 1'b0; m_write = 1'b0;
    m_addr = '0; m_wdata = '0; m_cool = 0; n_i_done = 0; n_d_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (i_drop) begin
        i_act = 1'b0; i_drop = 1'b0;
      end else if (!i_act && $urandom_range(0, 3) == 0) begin
        i_act = 1'b1; ia = $urandom() & 32'hFFFF_FFE0;
      end
      if (d_drop) begin
        d_act = 1'b0; d_drop = 1'b0;
      end else if (!d_act && $urandom_range(0, 3) == 0) begin
        int kind;
        kind = $urandom_range(0, 2);
        d_act = 1'b1; d_r = (kind != 1); d_w = (kind != 0);
        da = $urandom() & 32'hFFFF_FFE0; dwd = rand_line();
      end
      bus.i_read = i_act; bus.i_addr = ia;
      bus.d_read = d_act & d_r; bus.d_write = d_act & d_w;
      bus.d_addr = da; bus.d_wdata = dwd;
      if (bus.mem_read || bus.mem_write) begin
        if (!loaded) begin
          lat = $urandom_range(0, 3); loaded = 1'b1;
        end
        if (lat == 0) begin
          bus.mem_resp = 1'b1; loaded = 1'b0;
        end else begin
          lat--; bus.mem_resp = 1'b0;
        end
      end else begin
        bus.mem_resp = ($urandom_range(0, 7) == 0);
      end
      bus.mem_rdata = rand_line();
      #1;
      if (m_busy) begin
        check_bit("rnd.mem_read", bus.mem_read, !m_write);
        check_bit("rnd.mem_write", bus.mem_write, m_write);
        check_vec("rnd.mem_addr", LINE_W'(bus.mem_addr), LINE_W'(m_addr));
        if (m_write) check_vec("rnd.mem_wdata", bus.mem_wdata, m_wdata);
        check_bit("rnd.i_resp", bus.i_resp, !m_who && bus.mem_resp);
        check_bit("rnd.d_resp", bus.d_resp, m_who && bus.mem_resp);
        if (bus.mem_resp) begin
          if (m_who) begin
            check_vec("rnd.d_rdata", bus.d_rdata, bus.mem_rdata);
            d_drop = 1'b1; n_d_done++;
          end else begin
            check_vec("rnd.i_rdata", bus.i_rdata, bus.mem_rdata);
            i_drop = 1'b1; n_i_done++;
          end
          m_busy = 1'b0; m_cool = 1;
        end
      end else begin
        check_bit("rnd.idle_mem_read", bus.mem_read, 1'b0);
        check_bit("rnd.idle_mem_write", bus.mem_write, 1'b0);
        check_bit("rnd.idle_i_resp", bus.i_resp, 1'b0);
        check_bit("rnd.idle_d_resp", bus.d_resp, 1'b0);
        if (m_cool > 0) begin
          m_cool--;
        end else if (i_act || d_act) begin
          m_who   = (i_act && d_act) ? !m_last : d_act;
          m_last  = m_who;
          m_busy  = 1'b1;
          m_write = m_who ? d_w : 1'b0;
          m_addr  = m_who ? da : ia;
          m_wdata = dwd;
        end
      end
      tick();
    end
    total++;
    if (n_i_done == 0 || n_d_done == 0) begin
      bad++;
      $display("FAIL rnd.progress actual=i:%0d,d:%0d required=both nonzero", n_i_done, n_d_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
